instr_register_ext: RTL and testbench

INSTR_REGISTER_EXT -- requirements
Module: instr_register_ext

---
 rtl/instr_register_pkg.sv | 28 ++
 rtl/iw_pow_unit.sv | 53 +++++
 rtl/instr_register_ext.sv | 137 +++++++++++++
 tb/tb_instr_register_ext.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the extended instruction register.
//   opcode_t   : 4-bit operation code, ZERO..POW = 0..8. Codes 9..15 are undefined.
//   ir_state_t : controller states for the iterative POW path.
//   DEF_OP_W / DEF_DEPTH : default operand width and entry count.
package instr_register_pkg;

  localparam int DEF_OP_W  = 32;
  localparam int DEF_DEPTH = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7,
    POW   = 4'd8
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POW_RUN = 2'd1,
    POW_WR  = 2'd2
  } ir_state_t;

endpackage

// File: rtl/iw_pow_unit.sv
// Iterative a**b modulo 2^(2*OP_W), using right-to-left square-and-multiply.
//   clk, reset_n : clock and asynchronous active-low reset (reset aborts a run)
//   start        : load a/b and begin; the next OP_W edges each consume one exponent bit
//   a, b         : signed base and exponent (b is treated as non-negative by the caller)
//   done         : high during the final bit cycle; result is final after that edge
//   result       : running accumulator, 2*OP_W bits
module iw_pow_unit #(
  parameter int OP_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                done,
  output logic [2*OP_W-1:0]   result
);

  localparam int CW = $clog2(OP_W) + 1;

  logic              busy;
  logic [CW-1:0]     cnt;
  logic [OP_W-1:0]   expn;
  logic [2*OP_W-1:0] base, acc;

  // Unsigned multiplies are enough: the low 2*OP_W bits of a product do
  // not depend on signedness once the base is sign-extended.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      expn <= '0;
      base <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      expn <= b;
      base <= {{OP_W{a[OP_W-1]}}, a};
      acc  <= {{(2*OP_W-1){1'b0}}, 1'b1};
    end else if (busy) begin
      if (expn[0]) acc <= acc * base;
      base <= base * base;
      expn <= expn >> 1;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  assign done   = busy && (cnt == CW'(OP_W - 1));
  assign result = acc;

endmodule

// File: rtl/instr_register_ext.sv
// Instruction register file with a built-in ALU.
//   clk, reset_n      : clock, asynchronous active-low reset
//   load_en/load_rdy  : write handshake; accepted when both are high at a rising edge
//   write_pointer     : target entry; operand_a/operand_b/opcode give the operation
//   read_pointer      : entry presented combinationally on the read outputs
//   instruction_word  : packed {opc[3:0], op_a, op_b, rezultat[2*OP_W-1:0]}, MSB first
//   rd_valid, rd_err  : addressed entry written since reset / holds an error result
// Single-cycle ops go through a one-deep stage register and land one edge
// after acceptance. POW with a non-negative exponent runs in iw_pow_unit and
// holds off further writes until its entry is written.
module instr_register_ext
  import instr_register_pkg::*;
#(
  parameter int OP_W  = DEF_OP_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load_en,
  output logic                       load_rdy,
  input  logic [$clog2(DEPTH)-1:0]   write_pointer,
  input  logic [OP_W-1:0]            operand_a,
  input  logic [OP_W-1:0]            operand_b,
  input  opcode_t                    opcode,
  input  logic [$clog2(DEPTH)-1:0]   read_pointer,
  output logic [4+4*OP_W-1:0]        instruction_word,
  output logic                       rd_valid,
  output logic                       rd_err
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef struct packed {
    opcode_t                  opc;
    logic signed [OP_W-1:0]   op_a;
    logic signed [OP_W-1:0]   op_b;
    logic signed [2*OP_W-1:0] rezultat;
  } instr_word_t;

  instr_word_t             mem [DEPTH];
  logic [DEPTH-1:0]        vld, err;

  ir_state_t               state, state_nx;
  logic                    stg_vld;
  logic [ADDR_W-1:0]       stg_ptr;
  opcode_t                 stg_opc;
  logic [OP_W-1:0]         stg_a, stg_b;

  logic                    accept, pow_go, pow_done;
  logic [2*OP_W-1:0]       pow_res;
  logic signed [2*OP_W-1:0] a_x, b_x, alu_res;
  logic                    alu_err;

  assign load_rdy = reset_n && (state == IDLE);
  assign accept   = load_en && load_rdy;
  // Negative exponents take the single-cycle error path instead.
  assign pow_go   = accept && (opcode == POW) && !operand_b[OP_W-1];

  // Controller
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pow_go)   state_nx = POW_RUN;
      POW_RUN: if (pow_done) state_nx = POW_WR;
      POW_WR:                state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // ALU on the staged operands
  always_comb begin
    a_x     = {{OP_W{stg_a[OP_W-1]}}, stg_a};
    b_x     = {{OP_W{stg_b[OP_W-1]}}, stg_b};
    alu_res = '0;
    alu_err = 1'b0;
    case (stg_opc)
      ZERO:  alu_res = '0;
      PASSA: alu_res = a_x;
      PASSB: alu_res = b_x;
      ADD:   alu_res = a_x + b_x;
      SUB:   alu_res = a_x - b_x;
      MULT:  alu_res = a_x * b_x;
      DIV:   if (b_x == '0) alu_err = 1'b1; else alu_res = a_x / b_x;
      MOD:   if (b_x == '0) alu_err = 1'b1; else alu_res = a_x % b_x;
      default: alu_err = 1'b1;  // POW with b<0, or an undefined code
    endcase
  end

  iw_pow_unit #(.OP_W(OP_W)) u_pow (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (pow_go),
    .a       (operand_a),
    .b       (operand_b),
    .done    (pow_done),
    .result  (pow_res)
  );

  // Stage fields are reused to remember the POW target; stg_vld stays low
  // for that case so the single-cycle write path ignores it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      stg_vld <= 1'b0;
      stg_ptr <= '0;
      stg_opc <= ZERO;
      stg_a   <= '0;
      stg_b   <= '0;
      mem     <= '{default: '0};
      vld     <= '0;
      err     <= '0;
    end else begin
      state   <= state_nx;
      stg_vld <= accept && !pow_go;
      if (accept) begin
        stg_ptr <= write_pointer;
        stg_opc <= opcode;
        stg_a   <= operand_a;
        stg_b   <= operand_b;
      end
      if (stg_vld) begin
        mem[stg_ptr] <= '{opc: stg_opc, op_a: stg_a, op_b: stg_b, rezultat: alu_res};
        vld[stg_ptr] <= 1'b1;
        err[stg_ptr] <= alu_err;
      end else if (state == POW_WR) begin
        mem[stg_ptr] <= '{opc: stg_opc, op_a: stg_a, op_b: stg_b, rezultat: pow_res};
        vld[stg_ptr] <= 1'b1;
        err[stg_ptr] <= 1'b0;
      end
    end
  end

  assign instruction_word = mem[read_pointer];
  assign rd_valid         = vld[read_pointer];
  assign rd_err           = err[read_pointer];

endmodule

// File: tb/tb_instr_register_ext.sv
// Scoreboard bench for instr_register_ext (OP_W=32, DEPTH=32). Stimulus
// pushes the expected read-side view for a cycle; the monitor pops and
// compares at the falling edge of any cycle flagged with chk.
module tb_instr_register_ext;
  import instr_register_pkg::*;

  localparam int OP_W = 32;
  localparam int DEPTH = 32;
  localparam int IW_W = 4 + 4*OP_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              load_en;
  logic              load_rdy;
  logic [4:0]        write_pointer, read_pointer;
  logic [OP_W-1:0]   operand_a, operand_b;
  opcode_t           opcode;
  logic [IW_W-1:0]   instruction_word;
  logic              rd_valid, rd_err;

  instr_register_ext #(.OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_en          (load_en),
    .load_rdy         (load_rdy),
    .write_pointer    (write_pointer),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .opcode           (opcode),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .rd_valid         (rd_valid),
    .rd_err           (rd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW_W-1:0] iw;
    logic            v;
    logic            e;
    logic            r;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  chk = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic logic [IW_W-1:0] mk(input logic [3:0] opc, input logic signed [31:0] a,
                                         input logic signed [31:0] b, input logic signed [63:0] r);
    return {opc, a, b, r};
  endfunction

  // Advance to just after the next rising edge; per-cycle strobes drop here.
  task automatic tick();
    @(posedge clk);
    #1;
    chk     = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic ld(input logic [3:0] opc, input logic [4:0] ptr,
                    input logic signed [31:0] a, input logic signed [31:0] b);
    load_en       = 1'b1;
    opcode        = opcode_t'(opc);
    write_pointer = ptr;
    operand_a     = a;
    operand_b     = b;
  endtask

  task automatic rd(input string nm, input logic [4:0] ptr, input logic [IW_W-1:0] iw,
                    input logic v, input logic e, input logic r);
    exp_t x;
    x.iw = iw; x.v = v; x.e = e; x.r = r;
    read_pointer = ptr;
    exp_q.push_back(x);
    name_q.push_back(nm);
    chk = 1'b1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (chk) begin
      exp_t  x;
      string nm;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: monitor found no expected entry");
      end else begin
        x  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_chk++;
        if ({instruction_word, rd_valid, rd_err, load_rdy} !== {x.iw, x.v, x.e, x.r}) begin
          n_fail++;
          $display("FAIL %s ptr=%0d: got iw=%h v=%b e=%b rdy=%b, want iw=%h v=%b e=%b rdy=%b",
                   nm, read_pointer, instruction_word, rd_valid, rd_err, load_rdy,
                   x.iw, x.v, x.e, x.r);
        end
      end
    end
  end

  localparam logic [IW_W-1:0] Z = '0;

  initial begin
    reset_n = 1'b0; load_en = 1'b0; write_pointer = '0; read_pointer = '0;
    operand_a = '0; operand_b = '0; opcode = ZERO;
    tick(); tick();

    // Held in reset: everything reads zero and no write can be accepted
    rd("reset_hold", 5'd5, Z, 0, 0, 0); tick();
    reset_n = 1'b1;
    for (int p = 0; p < DEPTH; p++) begin
      rd("reset_sweep", 5'(p), Z, 0, 0, 1); tick();
    end

    // ADD -15+15 -> ptr3: old value until one edge after acceptance
    ld(4'd3, 5'd3, -15, 15); rd("add_pre", 5'd3, Z, 0, 0, 1); tick();
    rd("add_same_cycle", 5'd3, Z, 0, 0, 1); tick();
    rd("add_post", 5'd3, mk(4'd3, -15, 15, 0), 1, 0, 1); tick();

    // Back-to-back MULT / DIV / MOD
    ld(4'd5, 5'd0, -7, 9);   rd("b2b_c1", 5'd0, Z, 0, 0, 1); tick();
    ld(4'd6, 5'd1, -15, 4);  rd("b2b_c2", 5'd0, Z, 0, 0, 1); tick();
    ld(4'd7, 5'd2, -15, 4);  rd("mult_neg", 5'd0, mk(4'd5, -7, 9, -63), 1, 0, 1); tick();
    rd("div_trunc", 5'd1, mk(4'd6, -15, 4, -3), 1, 0, 1); tick();
    rd("mod_sign", 5'd2, mk(4'd7, -15, 4, -3), 1, 0, 1); tick();

    // Error results
    ld(4'd6, 5'd31, 5, 0); tick();
    ld(4'd8, 5'd30, 2, -1); tick();
    rd("div_by_zero", 5'd31, mk(4'd6, 5, 0, 0), 1, 1, 1); tick();
    rd("pow_neg_exp", 5'd30, mk(4'd8, 2, -1, 0), 1, 1, 1); tick();

    // Assorted ops, undefined opcode, and rewrite clearing err
    ld(4'd4, 5'd8, 100, -28); tick();
    ld(4'd1, 5'd9, -5, 77); tick();
    ld(4'd12, 5'd10, 3, 3); tick();
    ld(4'd6, 5'd11, 7, -2); tick();
    ld(4'd7, 5'd12, 15, -4); tick();
    ld(4'd3, 5'd31, 1, 2); tick();
    ld(4'd0, 5'd13, 9, 9); tick();
    tick();
    rd("sub", 5'd8, mk(4'd4, 100, -28, 128), 1, 0, 1); tick();
    rd("passa_sext", 5'd9, mk(4'd1, -5, 77, -5), 1, 0, 1); tick();
    rd("undef_opc", 5'd10, mk(4'd12, 3, 3, 0), 1, 1, 1); tick();
    rd("div_neg_div", 5'd11, mk(4'd6, 7, -2, -3), 1, 0, 1); tick();
    rd("mod_pos_div", 5'd12, mk(4'd7, 15, -4, 3), 1, 0, 1); tick();
    rd("rewrite_clr_err", 5'd31, mk(4'd3, 1, 2, 3), 1, 0, 1); tick();
    rd("zero_op", 5'd13, mk(4'd0, 9, 9, 0), 1, 0, 1); tick();

    // SUB just before POW 3**4; POW holds off writes for OP_W+1 cycles
    ld(4'd4, 5'd4, 10, 3); rd("pre_pow_rdy", 5'd4, Z, 0, 0, 1); tick();
    ld(4'd8, 5'd5, 3, 4);  rd("pow_accept_rdy", 5'd5, Z, 0, 0, 1); tick();
    rd("sub_before_pow", 5'd4, mk(4'd4, 10, 3, 7), 1, 0, 0); tick();
    for (int i = 1; i <= OP_W; i++) begin
      if (i == 3) ld(4'd3, 5'd6, 1, 1);
      rd("pow_busy", 5'd5, Z, 0, 0, 0); tick();
    end
    rd("pow_result", 5'd5, mk(4'd8, 3, 4, 81), 1, 0, 1); tick();
    rd("busy_load_ignored", 5'd6, Z, 0, 0, 1); tick();

    // Reset ten cycles into POW 2**10 aborts it
    ld(4'd8, 5'd7, 2, 10); rd("pow2_accept", 5'd7, Z, 0, 0, 1); tick();
    for (int i = 0; i < 10; i++) begin
      rd("pow2_busy", 5'd7, Z, 0, 0, 0); tick();
    end
    reset_n = 1'b0;
    rd("mid_reset_clears", 5'd5, Z, 0, 0, 0); tick();
    rd("mid_reset_hold", 5'd0, Z, 0, 0, 0); tick();
    reset_n = 1'b1;
    tick();
    rd("post_release_rdy", 5'd7, Z, 0, 0, 1); tick();
    repeat (30) tick();
    rd("pow_aborted", 5'd7, Z, 0, 0, 1); tick();

    // Normal operation resumes after reset
    ld(4'd2, 5'd7, 1, -9); tick();
    tick();
    rd("passb_after_reset", 5'd7, mk(4'd2, 1, -9, -9), 1, 0, 1); tick();
    tick();

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
